kmeans_centroid_updater: RTL and testbench

KMEANS_CENTROID_UPDATER -- requirements
Module: kmeans_centroid_updater

---
 rtl/kmeans_centroid_updater_pkg.sv | 9 +
 rtl/kmeans_centroid_updater_if.sv | 20 ++
 rtl/kmeans_centroid_updater_seq_divider.sv | 48 ++++
 rtl/kmeans_centroid_updater.sv | 88 ++++++++
 tb/tb_kmeans_centroid_updater.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/kmeans_centroid_updater_pkg.sv
// kmeans_centroid_updater_pkg: shared k-means constants, FSM encoding and index-to-(cluster,axis) mapping
package kmeans_centroid_updater_pkg;
  localparam int K = 3;
  localparam int NJ = 3 * K;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, COMMIT} state_e;
  // entry j is (cluster j/3, axis j%3) in the order x0,y0,z0,x1,y1,z1,x2,y2,z2
  localparam logic [NJ-1:0][1:0] IDX_CLUSTER = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [NJ-1:0][1:0] IDX_AXIS = {2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};
endpackage

// File: rtl/kmeans_centroid_updater_if.sv
// kmeans_centroid_updater_if: centroid updater bus
// master drives start, sums, counts and the init write; slave returns centroids, busy and done
interface kmeans_centroid_updater_if #(parameter int SUM_W = 16, parameter int CNT_W = 5, parameter int COORD_W = 8);
  logic start, init_we, busy, done;
  logic [SUM_W-1:0] sumx0, sumy0, sumz0, sumx1, sumy1, sumz1, sumx2, sumy2, sumz2;
  logic [CNT_W-1:0] cnt0, cnt1, cnt2;
  logic [1:0] init_k;
  logic [COORD_W-1:0] init_x, init_y, init_z;
  logic [COORD_W-1:0] cx0, cy0, cz0, cx1, cy1, cz1, cx2, cy2, cz2;
  modport master(
    output start, sumx0, sumy0, sumz0, sumx1, sumy1, sumz1, sumx2, sumy2, sumz2,
    output cnt0, cnt1, cnt2, init_we, init_k, init_x, init_y, init_z,
    input cx0, cy0, cz0, cx1, cy1, cz1, cx2, cy2, cz2, busy, done
  );
  modport slave(
    input start, sumx0, sumy0, sumz0, sumx1, sumy1, sumz1, sumx2, sumy2, sumz2,
    input cnt0, cnt1, cnt2, init_we, init_k, init_x, init_y, init_z,
    output cx0, cy0, cz0, cx1, cy1, cz1, cx2, cy2, cz2, busy, done
  );
endinterface

// File: rtl/kmeans_centroid_updater_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle, ready pulses NW cycles after go
// ports: clk, rst, go_i (start with dividend_i), divisor_i (held stable while running), ready_o, quotient_o
module seq_divider #(parameter int NW = 16, parameter int DW = 5) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          ready_o,
  output logic [NW-1:0] quotient_o
);
  localparam int CW = $clog2(NW + 1);
  logic [DW-1:0] rem_q, rem_src, rem_d;
  logic [NW-1:0] quo_q, quo_src, quo_d;
  logic [DW:0] trial;
  logic [CW-1:0] cnt_q;
  logic ready_q, fit;
  // the go cycle already performs the first step, so NW-1 more steps follow
  always_comb begin
    rem_src = go_i ? '0 : rem_q;
    quo_src = go_i ? dividend_i : quo_q;
    trial = {rem_src, quo_src[NW-1]};
    fit = trial >= {1'b0, divisor_i};
    rem_d = fit ? DW'(trial - {1'b0, divisor_i}) : trial[DW-1:0];
    quo_d = {quo_src[NW-2:0], fit};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (go_i) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= CW'(NW - 1);
      end else if (cnt_q != '0) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        cnt_q <= cnt_q - 1'b1;
        ready_q <= cnt_q == CW'(1);
      end
    end
  assign ready_o = ready_q;
  assign quotient_o = quo_q;
endmodule

// File: rtl/kmeans_centroid_updater.sv
// kmeans_centroid_updater: recomputes 3 centroids as saturated floor(sum/cnt), committing all 9 at once
// ports: clk, rst (async, active-high), bus (slave: start/sums/counts/init write in, centroids/busy/done out)
module kmeans_centroid_updater
  import kmeans_centroid_updater_pkg::*;
#(parameter int SUM_W = 16, parameter int CNT_W = 5, parameter int COORD_W = 8) (
  input logic clk,
  input logic rst,
  kmeans_centroid_updater_if.slave bus
);
  state_e state_q;
  logic [3:0] idx_q;
  logic busy_q, done_q, div_go, div_ready;
  logic [SUM_W-1:0] sum_q [NJ];
  logic [CNT_W-1:0] cnt_q [K];
  logic [COORD_W-1:0] shadow_q [NJ];
  logic [COORD_W-1:0] cx_q [NJ];
  logic [CNT_W-1:0] div_cnt;
  logic [SUM_W-1:0] quo;
  logic [COORD_W-1:0] quo_sat;
  // a zero count never reaches the divider; that entry keeps its old centroid
  always_comb begin
    div_cnt = cnt_q[IDX_CLUSTER[idx_q]];
    div_go = state_q == ISSUE && div_cnt != '0;
    quo_sat = |quo[SUM_W-1:COORD_W] ? '1 : quo[COORD_W-1:0];
  end
  seq_divider #(.NW(SUM_W), .DW(CNT_W)) u_div (
    .clk(clk),
    .rst(rst),
    .go_i(div_go),
    .dividend_i(sum_q[idx_q]),
    .divisor_i(div_cnt),
    .ready_o(div_ready),
    .quotient_o(quo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q <= '{default: '0};
      cnt_q <= '{default: '0};
      shadow_q <= '{default: '0};
      cx_q <= '{default: '0};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE:
          if (bus.start) begin
            state_q <= ISSUE;
            busy_q <= 1'b1;
            idx_q <= '0;
            sum_q <= '{bus.sumx0, bus.sumy0, bus.sumz0, bus.sumx1, bus.sumy1, bus.sumz1, bus.sumx2, bus.sumy2, bus.sumz2};
            cnt_q <= '{bus.cnt0, bus.cnt1, bus.cnt2};
            shadow_q <= cx_q;
          end else if (bus.init_we)
            // init_k=3 matches no entry and is dropped
            for (int j = 0; j < NJ; j++)
              if (IDX_CLUSTER[j] == bus.init_k)
                cx_q[j] <= IDX_AXIS[j] == 2'd0 ? bus.init_x : IDX_AXIS[j] == 2'd1 ? bus.init_y : bus.init_z;
        ISSUE: state_q <= div_cnt != '0 ? WAIT : WRITE;
        WAIT: state_q <= div_ready ? WRITE : WAIT;
        WRITE: begin
          if (div_cnt != '0) shadow_q[idx_q] <= quo_sat;
          state_q <= idx_q == 4'd8 ? COMMIT : ISSUE;
          idx_q <= idx_q == 4'd8 ? '0 : idx_q + 4'd1;
        end
        COMMIT: begin
          cx_q <= shadow_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.cx0 = cx_q[0];
  assign bus.cy0 = cx_q[1];
  assign bus.cz0 = cx_q[2];
  assign bus.cx1 = cx_q[3];
  assign bus.cy1 = cx_q[4];
  assign bus.cz1 = cx_q[5];
  assign bus.cx2 = cx_q[6];
  assign bus.cy2 = cx_q[7];
  assign bus.cz2 = cx_q[8];
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_kmeans_centroid_updater.sv
// tb_kmeans_centroid_updater: randomized bench against a centroid/latency reference model
module tb_kmeans_centroid_updater;
  localparam int SUM_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic expect_chg = 1'b1;
  logic [7:0] model [9];
  logic [15:0] s [9];
  logic [4:0] c [3];
  logic [71:0] cxv, prev_cxv = '0;
  kmeans_centroid_updater_if #(.SUM_W(16), .CNT_W(5), .COORD_W(8)) bus ();
  kmeans_centroid_updater #(.SUM_W(16), .CNT_W(5), .COORD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign cxv = {bus.cz2, bus.cy2, bus.cx2, bus.cz1, bus.cy1, bus.cx1, bus.cz0, bus.cy0, bus.cx0};

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mvec();
    logic [71:0] v;
    for (int j = 0; j < 9; j++) v[j*8 +: 8] = model[j];
    return v;
  endfunction

  // centroids may only move when idle, and then only in a done cycle or after an init write/reset
  always @(negedge clk) begin
    if (cxv !== prev_cxv) chk("cx_stable", {71'd0, !bus.busy && (bus.done || expect_chg)}, 72'd1);
    prev_cxv = cxv;
  end

  task automatic drive();
    {bus.sumx0, bus.sumy0, bus.sumz0} = {s[0], s[1], s[2]};
    {bus.sumx1, bus.sumy1, bus.sumz1} = {s[3], s[4], s[5]};
    {bus.sumx2, bus.sumy2, bus.sumz2} = {s[6], s[7], s[8]};
    {bus.cnt0, bus.cnt1, bus.cnt2} = {c[0], c[1], c[2]};
  endtask

  task automatic rnd_sums();
    for (int j = 0; j < 9; j++) s[j] = 16'($urandom);
  endtask

  task automatic rnd_cnts(input bit allow_zero);
    for (int k = 0; k < 3; k++)
      c[k] = (allow_zero && $urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endtask

  task automatic init_write(input logic [1:0] k, input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    bus.init_we = 1'b1;
    bus.init_k = k;
    {bus.init_x, bus.init_y, bus.init_z} = {x, y, z};
    expect_chg = 1'b1;
    tick();
    bus.init_we = 1'b0;
    if (k != 2'd3) {model[3*k], model[3*k+1], model[3*k+2]} = {x, y, z};
    chk("init", cxv, mvec());
    @(negedge clk);
    #1 expect_chg = 1'b0;
    tick();
  endtask

  // xs: cycle of an extra start pulse, ra: cycle of a mid-run reset (0 = none)
  task automatic run(input int xs, input int ra);
    int cyc, lat, dones;
    logic [7:0] want [9];
    logic [15:0] q;
    lat = 2;
    for (int j = 0; j < 9; j++) begin
      want[j] = model[j];
      if (c[j/3] != 0) begin
        q = s[j] / 16'(c[j/3]);
        want[j] = q > 16'd255 ? 8'd255 : q[7:0];
        lat += SUM_W + 2;
      end else lat += 2;
    end
    drive();
    bus.start = 1'b1;
    bus.init_we = 1'b1;
    bus.init_k = 2'd0;
    {bus.init_x, bus.init_y, bus.init_z} = 24'($urandom);
    tick();
    bus.start = 1'b0;
    bus.init_we = 1'b0;
    rnd_sums();
    rnd_cnts(1'b1);
    drive();
    chk("busy_set", {71'd0, bus.busy}, 72'd1);
    bus.init_k = 2'($urandom_range(0, 2));
    cyc = 1;
    while (!bus.done && cyc < 400) begin
      bus.start = cyc == xs;
      bus.init_we = cyc == 10;
      if (cyc == ra) begin
        bus.start = 1'b0;
        bus.init_we = 1'b0;
        rst = 1'b1;
        expect_chg = 1'b1;
        #2;
        chk("abort_busy", {71'd0, bus.busy}, 72'd0);
        chk("abort_done", {71'd0, bus.done}, 72'd0);
        chk("abort_cx", cxv, 72'd0);
        @(negedge clk);
        #1 expect_chg = 1'b0;
        rst = 1'b0;
        for (int j = 0; j < 9; j++) model[j] = 8'd0;
        dones = 0;
        repeat (200) begin
          tick();
          if (bus.done) dones++;
        end
        chk("abort_no_done", 72'(dones), 72'd0);
        return;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    bus.init_we = 1'b0;
    chk("latency", 72'(cyc), 72'(lat));
    chk("busy_in_done", {71'd0, bus.busy}, 72'd0);
    for (int j = 0; j < 9; j++) model[j] = want[j];
    chk("centroids", cxv, mvec());
    tick();
    chk("done_pulse", {71'd0, bus.done}, 72'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.init_we = 1'b0;
    bus.init_k = 2'd0;
    {bus.init_x, bus.init_y, bus.init_z} = '0;
    for (int j = 0; j < 9; j++) model[j] = 8'd0;
    rnd_sums();
    rnd_cnts(1'b0);
    drive();
    repeat (2) tick();
    chk("rst_busy", {71'd0, bus.busy}, 72'd0);
    chk("rst_done", {71'd0, bus.done}, 72'd0);
    chk("rst_cx", cxv, 72'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    expect_chg = 1'b0;
    tick();
    init_write(2'd1, 8'd10, 8'd20, 8'd30);
    rnd_sums();
    rnd_cnts(1'b0);
    {s[3], s[4], s[5]} = {16'd100, 16'd40, 16'd7};
    c[1] = 5'd4;
    run(0, 0);
    chk("basic_cx1", 72'(bus.cx1), 72'd25);
    chk("basic_cy1", 72'(bus.cy1), 72'd10);
    chk("basic_cz1", 72'(bus.cz1), 72'd1);
    init_write(2'd2, 8'd5, 8'd6, 8'd7);
    rnd_sums();
    rnd_cnts(1'b0);
    c[2] = 5'd0;
    run(0, 0);
    chk("zero_cx2", 72'({bus.cx2, bus.cy2, bus.cz2}), 72'h050607);
    rnd_sums();
    {s[0], s[3], s[6]} = {16'd5100, 16'd10, 16'd65535};
    {c[0], c[1], c[2]} = {5'd20, 5'd3, 5'd1};
    run(0, 0);
    chk("div_exact", 72'(bus.cx0), 72'd255);
    chk("div_trunc", 72'(bus.cx1), 72'd3);
    chk("div_sat", 72'(bus.cx2), 72'd255);
    init_write(2'd3, 8'd99, 8'd98, 8'd97);
    rnd_sums();
    rnd_cnts(1'b0);
    run(50, 0);
    rnd_sums();
    rnd_cnts(1'b0);
    run(0, 80);
    rnd_sums();
    rnd_cnts(1'b0);
    run(0, 0);
    repeat (6) begin
      init_write(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
      rnd_sums();
      rnd_cnts(1'b1);
      run(0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
